rect_compositor: RTL and testbench
==================================

// Module: rect_compositor
// PURPOSE
//  Parametrised multi-rectangle overlay for the pixel stream.
//  - Holds NUM_RECTS rectangles (x, y, w, h, color, enable) in double-buffered config registers.
//  - Each streamed pixel is tested against all rectangles; the highest-priority hit replaces the background color.
//  - Sits between the pixel coordinate generator and the display output stage.
//  - Generalises the single-square hit test: N channels, independent w/h, registered pipeline, backpressure, frame-synchronous config.
// PARAMETERS
//  NUM_RECTS  4   number of rectangle channels (1..16); index 0 = highest priority
//  COORD_W    13  pixel coordinate width
//  SIZE_W     11  rectangle width/height field width
//  COLOR_W    20  color word width
// PORTS
//  clk        in   1                   single clock; all logic on rising edge
//  rst        in   1                   synchronous, active-high reset
//  cfg_we     in   1                   write shadow entry cfg_idx this cycle
//  cfg_idx    in   $clog2(NUM_RECTS)   shadow entry select (max(1,...) bits)
//  cfg_x      in   COORD_W             rectangle left edge
//  cfg_y      in   COORD_W             rectangle top edge
//  cfg_w      in   SIZE_W              rectangle width, in pixels
//  cfg_h      in   SIZE_W              rectangle height, in pixels
//  cfg_color  in   COLOR_W             fill color
//  cfg_en     in   1                   rectangle enable
//  cfg_commit in   1                   request shadow->active copy at next frame start
//  commit_pend out 1                   commit requested, not yet applied
//  in_valid   in   1                   input pixel valid
//  in_ready   out  1                   input pixel accepted when in_valid & in_ready
//  in_sof     in   1                   pixel is first of frame (qualified by in_valid)
//  in_x       in   COORD_W             pixel x
//  in_y       in   COORD_W             pixel y
//  in_color   in   COLOR_W             background color
//  out_valid  out  1                   output pixel valid
//  out_ready  in   1                   downstream accepts output
//  out_color  out  COLOR_W             composited color
//  out_hit    out  1                   some rectangle covered the pixel
//  out_idx    out  $clog2(NUM_RECTS)   winning rectangle index (0 if no hit)
// BEHAVIOUR
//  Reset:
//   - all shadow/active entries cleared (en=0).
//   - commit_pend=0, out_valid=0, out_color=0, out_hit=0, out_idx=0, in_ready=1 the cycle after rst falls.
//  Hit test:
//   - x_r <= px < x_r+w_r and y_r <= py < y_r+h_r.
//   - Sums computed at COORD_W+1 bits, so no wrap; a rectangle past the edge clips, never aliases to 0.
//   - w=0 or h=0 never hits; en=0 never hits.
//  Priority: lowest hitting index wins; no hit -> out_color=in_color, out_hit=0, out_idx=0.
//  Pipeline:
//   - 2 stages: S1 registers per-rect hit vector + pixel; S2 registers priority-encoded result.
//   - Latency 2 cycles accept->out_valid with no stall.
//   - Stage advances when downstream stage empty or consumed.
//   - in_ready = !s1_valid | s1_advance; no bubbles at full throughput.
//   - Output held stable while out_valid & !out_ready.
//  Config:
//   - cfg_we writes shadow only, any time.
//   - cfg_commit sets commit_pend.
//   - Copy to active occurs on the cycle a pixel with in_sof=1 is accepted; that pixel and all later ones use the new set.
//   - commit_pend clears in that same cycle.
//   - cfg_we and the commit copy in the same cycle: the copy takes the pre-write shadow value; the write lands in shadow.
//   - cfg_commit while pending: no effect (stays pending).
//   - cfg_commit coinciding with an accepted in_sof: applies immediately.
//   - Pixels in flight keep the hit vector computed in S1; rectangle colors for S2 come from a per-pixel snapshot (color latched in S1).
//  Reset mid-frame/mid-stall: pipeline flushed, in-flight pixels dropped, no partial output.
// STRUCTURE
//  - Package rect_pkg: rect_t struct {x, y, w, h, color, en}; COORD_W, SIZE_W, COLOR_W defaults; pixel_t {x, y, color, sof}.
//  - Sub-module rect_hit: combinational single-rectangle hit test (rect_t, px, py) -> hit; instantiated NUM_RECTS times via generate.
//  - Priority encoder and skid-free pipeline remain in the top.
// TESTING
//  - Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_color=0, commit_pend=0, in_ready=1 afterwards.
//  - Edges: rect0 x=10,y=20,w=5,h=3 committed.
//    - Pixels (10,20),(14,22) hit, idx0.
//    - Pixels (15,20),(10,23),(9,20) miss, background passes.
//  - Overlap: rect0 at (0,0,8,8) color 0x00F00, rect2 at (4,4,8,8) color 0x0F000.
//    - Pixel (5,5) -> 0x00F00, idx0.
//    - Pixel (9,9) -> 0x0F000, idx2.
//  - Clip/zero: rect1 x=8190,w=10 -> hits x=8191, no hit at x=0; rect with w=0 never hits.
//  - Commit timing: change rect0 color mid-frame, assert cfg_commit.
//    - Old color continues until the in_sof pixel.
//    - commit_pend=1 until then.
//    - The sof pixel onward carries the new color.
//  - Backpressure: random out_ready with continuous in_valid.
//    - Output sequence identical to the no-stall reference model.
//    - Held outputs stable.
//    - No pixel lost or duplicated; throughput 1/clk when out_ready=1.

Source files
------------

// File: rtl/rect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_pkg
//  Description : Shared widths and record types for the rectangle compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_pkg;

    localparam int COORD_W_DEF = 13;
    localparam int SIZE_W_DEF  = 11;
    localparam int COLOR_W_DEF = 20;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [SIZE_W_DEF-1:0]  w;
        logic [SIZE_W_DEF-1:0]  h;
        logic [COLOR_W_DEF-1:0] color;
        logic                   en;
    } rect_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COLOR_W_DEF-1:0] color;
        logic                   sof;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/rect_hit.sv
`default_nettype none
// ============================================================================
//  Module      : rect_hit
//  Description : Combinational point-in-rectangle test for one channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_hit
    import rect_pkg::*;
(
    input  rect_t                  i_rect,
    input  logic [COORD_W_DEF-1:0] i_px,
    input  logic [COORD_W_DEF-1:0] i_py,
    output logic                   o_hit,
    output logic [COLOR_W_DEF-1:0] o_color
);

    // One extra bit on the far edge so a rectangle hanging off the frame clips.
    logic [COORD_W_DEF:0] w_x_end;
    logic [COORD_W_DEF:0] w_y_end;
    logic                 w_in_x;
    logic                 w_in_y;

    assign w_x_end = {1'b0, i_rect.x} + (COORD_W_DEF+1)'(i_rect.w);
    assign w_y_end = {1'b0, i_rect.y} + (COORD_W_DEF+1)'(i_rect.h);

    assign w_in_x  = (i_px >= i_rect.x) && ({1'b0, i_px} < w_x_end);
    assign w_in_y  = (i_py >= i_rect.y) && ({1'b0, i_py} < w_y_end);

    assign o_hit   = i_rect.en && w_in_x && w_in_y;
    assign o_color = i_rect.color;

endmodule
`default_nettype wire

// File: rtl/rect_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : rect_compositor
//  Description : N-rectangle priority overlay on a valid/ready pixel stream,
//                two-stage pipeline, frame-synchronous double-buffered config.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_compositor
    import rect_pkg::*;
#(
    parameter int  NUM_RECTS = 4,
    parameter int  COORD_W   = rect_pkg::COORD_W_DEF,
    parameter int  SIZE_W    = rect_pkg::SIZE_W_DEF,
    parameter int  COLOR_W   = rect_pkg::COLOR_W_DEF,
    localparam int IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [SIZE_W-1:0]  cfg_w,
    input  logic [SIZE_W-1:0]  cfg_h,
    input  logic [COLOR_W-1:0] cfg_color,
    input  logic               cfg_en,
    input  logic               cfg_commit,
    output logic               commit_pend,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [COLOR_W-1:0] in_color,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_idx
);

    // Rectangle storage uses the package record, so width parameters are
    // expected to stay at the package defaults.
    rect_t              r_shadow [NUM_RECTS];
    rect_t              r_active [NUM_RECTS];
    rect_t              w_eff    [NUM_RECTS];
    rect_t              w_cfg_rect;
    logic               r_commit_pend;

    logic               w_s2_ready;
    logic               w_s1_advance;
    logic               w_fire;
    logic               w_commit_now;

    logic [NUM_RECTS-1:0] w_hit;
    logic [COLOR_W-1:0]   w_rect_color [NUM_RECTS];

    logic                 r_s1_valid;
    logic [NUM_RECTS-1:0] r_s1_hit;
    logic [COLOR_W-1:0]   r_s1_bg;
    logic [COLOR_W-1:0]   r_s1_rc [NUM_RECTS];

    logic                 w_enc_hit;
    logic [IDX_W-1:0]     w_enc_idx;
    logic [COLOR_W-1:0]   w_enc_color;

    logic                 r_s2_valid;
    logic [COLOR_W-1:0]   r_out_color;
    logic                 r_out_hit;
    logic [IDX_W-1:0]     r_out_idx;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_s2_ready   = !r_s2_valid || out_ready;
    assign w_s1_advance = r_s1_valid && w_s2_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_fire       = in_valid && in_ready;
    assign w_commit_now = w_fire && in_sof && (r_commit_pend || cfg_commit);

    // ------------------------------------------------------------------
    // Configuration: shadow writes any time, copy on accepted frame start
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_rect       = '0;
        w_cfg_rect.x     = cfg_x;
        w_cfg_rect.y     = cfg_y;
        w_cfg_rect.w     = cfg_w;
        w_cfg_rect.h     = cfg_h;
        w_cfg_rect.color = cfg_color;
        w_cfg_rect.en    = cfg_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_pend <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_commit_now) begin
                r_commit_pend <= 1'b0;
            end else if (cfg_commit) begin
                r_commit_pend <= 1'b1;
            end
            // The copy reads pre-write shadow contents; a same-cycle write stays in shadow.
            if (w_commit_now) begin
                for (int i = 0; i < NUM_RECTS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_RECTS))) begin
                r_shadow[cfg_idx] <= w_cfg_rect;
            end
        end
    end

    assign commit_pend = r_commit_pend;

    // The frame-start pixel that triggers a commit already sees the new set.
    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_eff[i] = w_commit_now ? r_shadow[i] : r_active[i];
        end
    end

    // ------------------------------------------------------------------
    // Per-rectangle hit test
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        rect_hit u_rect_hit (
            .i_rect  (w_eff[g]),
            .i_px    (in_x),
            .i_py    (in_y),
            .o_hit   (w_hit[g]),
            .o_color (w_rect_color[g])
        );
    end

    // ------------------------------------------------------------------
    // Stage 1: hit vector, background and color snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s1_bg    <= '0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_s1_rc[i] <= '0;
            end
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_hit <= w_hit;
                r_s1_bg  <= in_color;
                for (int i = 0; i < NUM_RECTS; i++) begin
                    r_s1_rc[i] <= w_rect_color[i];
                end
            end
        end
    end

    // Lowest index wins: scan downwards so the last assignment is the winner.
    always_comb begin
        w_enc_hit   = 1'b0;
        w_enc_idx   = '0;
        w_enc_color = r_s1_bg;
        for (int i = NUM_RECTS-1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_enc_hit   = 1'b1;
                w_enc_idx   = IDX_W'(i);
                w_enc_color = r_s1_rc[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: composited output, held while stalled
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_out_color <= '0;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_color <= w_enc_color;
                r_out_hit   <= w_enc_hit;
                r_out_idx   <= w_enc_idx;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_color = r_out_color;
    assign out_hit   = r_out_hit;
    assign out_idx   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_rect_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_compositor
//  Description : Self-checking bench: directed corner cases plus randomized
//                traffic scored against a behavioural overlay model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_compositor;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [12:0] cfg_x = '0;
    logic [12:0] cfg_y = '0;
    logic [10:0] cfg_w = '0;
    logic [10:0] cfg_h = '0;
    logic [19:0] cfg_color = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_commit = 1'b0;
    logic        commit_pend;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [12:0] in_x = '0;
    logic [12:0] in_y = '0;
    logic [19:0] in_color = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_color;
    logic        out_hit;
    logic [1:0]  out_idx;

    always #5 clk = ~clk;

    rect_compositor #(.NUM_RECTS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_w       (cfg_w),
        .cfg_h       (cfg_h),
        .cfg_color   (cfg_color),
        .cfg_en      (cfg_en),
        .cfg_commit  (cfg_commit),
        .commit_pend (commit_pend),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_color    (in_color),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_color   (out_color),
        .out_hit     (out_hit),
        .out_idx     (out_idx)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        int x; int y; int w; int h; int color; bit en;
    } mrect_t;

    typedef struct {
        int color; bit hit; int idx;
    } exp_t;

    mrect_t m_shadow [N];
    mrect_t m_active [N];
    bit     m_pend = 1'b0;
    exp_t   exp_q [$];

    function automatic exp_t model_pixel(input int px, input int py, input int bg);
        exp_t e;
        e.color = bg;
        e.hit   = 1'b0;
        e.idx   = 0;
        for (int i = 0; i < N; i++) begin
            if (m_active[i].en &&
                px >= m_active[i].x && px < m_active[i].x + m_active[i].w &&
                py >= m_active[i].y && py < m_active[i].y + m_active[i].h) begin
                e.color = m_active[i].color;
                e.hit   = 1'b1;
                e.idx   = i;
                return e;
            end
        end
        return e;
    endfunction

    bit          mon_stall = 1'b0;
    logic [19:0] st_color;
    logic        st_hit;
    logic [1:0]  st_idx;
    bit          chk_thru = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   commit_now;
        if (rst) begin
            exp_q.delete();
            m_pend    = 1'b0;
            mon_stall = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = '{0, 0, 0, 0, 0, 1'b0};
                m_active[i] = '{0, 0, 0, 0, 0, 1'b0};
            end
        end else begin
            check("commit_pend", 64'(commit_pend), 64'(m_pend));
            if (mon_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_color", 64'(out_color), 64'(st_color));
                check("hold_hit",   64'(out_hit),   64'(st_hit));
                check("hold_idx",   64'(out_idx),   64'(st_idx));
            end
            mon_stall = out_valid && !out_ready;
            st_color  = out_color;
            st_hit    = out_hit;
            st_idx    = out_idx;

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_without_input", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_color", 64'(out_color), 64'(e.color));
                    check("out_hit",   64'(out_hit),   64'(e.hit));
                    check("out_idx",   64'(out_idx),   64'(e.idx));
                end
            end

            if (chk_thru && out_ready) begin
                check("thru_in_ready", 64'(in_ready), 64'd1);
            end

            commit_now = 1'b0;
            if (in_valid && in_ready) begin
                commit_now = in_sof && (m_pend || cfg_commit);
                if (commit_now) m_active = m_shadow;
                exp_q.push_back(model_pixel(int'(in_x), int'(in_y), int'(in_color)));
            end
            if (commit_now)      m_pend = 1'b0;
            else if (cfg_commit) m_pend = 1'b1;
            if (cfg_we) begin
                m_shadow[int'(cfg_idx)] = '{int'(cfg_x), int'(cfg_y), int'(cfg_w),
                                            int'(cfg_h), int'(cfg_color), cfg_en};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wr_rect(input int idx, input int x, input int y, input int w,
                           input int h, input int color, input bit en);
        @(posedge clk); #1;
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_x     = 13'(x);
        cfg_y     = 13'(y);
        cfg_w     = 11'(w);
        cfg_h     = 11'(h);
        cfg_color = 20'(color);
        cfg_en    = en;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    task automatic commit_req();
        @(posedge clk); #1;
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
    endtask

    task automatic send_px(input int x, input int y, input bit sof, input int bg,
                           input int ec, input bit eh, input int ei, input string tag);
        int lat;
        bit got;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_x      = 13'(x);
        in_y      = 13'(y);
        in_sof    = sof;
        in_color  = 20'(bg);
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        got = 1'b0;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(lat), 64'd2);
            check({tag, "_color"},   64'(out_color), 64'(ec));
            check({tag, "_hit"},     64'(out_hit),   64'(eh));
            check({tag, "_idx"},     64'(out_idx),   64'(ei));
        end
    endtask

    localparam int BG = 20'h55555;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with traffic presented
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_color",   64'(out_color),   64'd0);
        check("rst_out_hit",     64'(out_hit),     64'd0);
        check("rst_out_idx",     64'(out_idx),     64'd0);
        check("rst_commit_pend", 64'(commit_pend), 64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);

        // Edges of a 5x3 rectangle
        wr_rect(0, 10, 20, 5, 3, 20'hAAAAA, 1'b1);
        commit_req();
        send_px(10, 20, 1'b1, BG, 20'hAAAAA, 1'b1, 0, "edge_tl");
        send_px(14, 22, 1'b0, BG, 20'hAAAAA, 1'b1, 0, "edge_br");
        send_px(15, 20, 1'b0, BG, BG, 1'b0, 0, "edge_right_out");
        send_px(10, 23, 1'b0, BG, BG, 1'b0, 0, "edge_bottom_out");
        send_px(9,  20, 1'b0, BG, BG, 1'b0, 0, "edge_left_out");

        // Overlap priority
        wr_rect(0, 0, 0, 8, 8, 20'h00F00, 1'b1);
        wr_rect(2, 4, 4, 8, 8, 20'h0F000, 1'b1);
        commit_req();
        send_px(5, 5, 1'b1, BG, 20'h00F00, 1'b1, 0, "ovl_both");
        send_px(9, 9, 1'b0, BG, 20'h0F000, 1'b1, 2, "ovl_r2");

        // Right-edge clipping and zero-width rectangle
        wr_rect(0, 0, 0, 8, 8, 20'h00F00, 1'b0);
        wr_rect(2, 4, 4, 8, 8, 20'h0F000, 1'b0);
        wr_rect(1, 8190, 0, 10, 4, 20'hABCDE, 1'b1);
        wr_rect(3, 0, 0, 0, 5, 20'h11111, 1'b1);
        commit_req();
        send_px(8191, 0, 1'b1, BG, 20'hABCDE, 1'b1, 1, "clip_hit");
        send_px(0,    0, 1'b0, BG, BG, 1'b0, 0, "clip_no_alias");
        send_px(8190, 3, 1'b0, BG, 20'hABCDE, 1'b1, 1, "clip_last_row");
        send_px(8191, 4, 1'b0, BG, BG, 1'b0, 0, "clip_below");

        // Commit waits for the next frame start
        wr_rect(1, 8190, 0, 10, 4, 20'h12345, 1'b1);
        commit_req();
        @(negedge clk);
        check("pend_after_req", 64'(commit_pend), 64'd1);
        send_px(8191, 1, 1'b0, BG, 20'hABCDE, 1'b1, 1, "commit_old");
        check("pend_mid_frame", 64'(commit_pend), 64'd1);
        send_px(8191, 1, 1'b1, BG, 20'h12345, 1'b1, 1, "commit_sof");
        check("pend_cleared", 64'(commit_pend), 64'd0);
        send_px(8191, 2, 1'b0, BG, 20'h12345, 1'b1, 1, "commit_after");

        // Randomized traffic with backpressure and config churn
        chk_thru = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_x      = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(8180, 8191))
                                                    : 13'($urandom_range(0, 63));
            in_y      = 13'($urandom_range(0, 63));
            in_color  = 20'($urandom);
            in_sof    = ($urandom_range(0, 24) == 0);
            out_ready = (c >= 2500) ? 1'b1 : ($urandom_range(0, 99) < 60);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_idx   = 2'($urandom_range(0, N-1));
            cfg_x     = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(8170, 8191))
                                                    : 13'($urandom_range(0, 60));
            cfg_y     = 13'($urandom_range(0, 60));
            cfg_w     = 11'($urandom_range(0, 40));
            cfg_h     = 11'($urandom_range(0, 40));
            cfg_color = 20'($urandom);
            cfg_en    = ($urandom_range(0, 3) != 0);
            cfg_commit = ($urandom_range(0, 14) == 0);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        out_ready  = 1'b1;
        chk_thru   = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset while the pipeline is full and stalled
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("midrst_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
